// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALU/mux select codes and the control-output bundle.
package mips_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       pcwrite;
    logic       branch;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_rom.sv
// Moore output decode: maps the current state to the control bundle.
// Any encoding outside the defined state set yields an all-zero bundle.
module mc_ctrl_rom
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  logic in_range;
  assign in_range = (state == STATE_W'(state[STATE_BITS-1:0]));

  always_comb begin
    ctrl = '0;
    if (in_range) begin
      case (state_e'(state[STATE_BITS-1:0]))
        S_FETCH: begin
          ctrl.irwrite = 1'b1;
          ctrl.alusrcb = SRCB_FOUR;
          ctrl.pcsrc   = PCSRC_ALU;
          ctrl.pcwrite = 1'b1;
          ctrl.aluop   = ALUOP_ADD;
        end
        S_DECODE: begin
          ctrl.alusrcb = SRCB_IMMSH;
          ctrl.aluop   = ALUOP_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = SRCB_IMM;
        end
        S_MEMRD: ctrl.iord = 1'b1;
        S_MEMWB: begin
          ctrl.memtoreg = 1'b1;
          ctrl.regwrite = 1'b1;
        end
        S_MEMWR: begin
          ctrl.iord     = 1'b1;
          ctrl.memwrite = 1'b1;
        end
        S_EXECUTE: begin
          ctrl.alusrca = 1'b1;
          ctrl.aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ctrl.regdst   = 1'b1;
          ctrl.regwrite = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alusrca = 1'b1;
          ctrl.aluop   = ALUOP_SUB;
          ctrl.pcsrc   = PCSRC_ALUOUT;
          ctrl.branch  = 1'b1;
        end
        S_ADDIWB: ctrl.regwrite = 1'b1;
        S_JUMP: begin
          ctrl.pcsrc   = PCSRC_JUMP;
          ctrl.pcwrite = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: state register, next-state logic and pcen.
// Define MC_CONTROLLER_BNE_EN to route bne (000101) through BRANCH with inverted zero.
module mc_controller
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic               pcen,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic [STATE_W-1:0] state
);

  if (STATE_W < STATE_BITS) begin : g_bad_state_w
    $error("mc_controller: STATE_W must be at least 4");
  end

  function automatic logic [STATE_W-1:0] enc(input state_e s);
    return STATE_W'(s);
  endfunction

  logic [STATE_W-1:0] state_q;
  logic               in_range;
  ctrl_t              ctrl;

  assign in_range = (state_q == STATE_W'(state_q[STATE_BITS-1:0]));

`ifdef MC_CONTROLLER_BNE_EN
  // Remembers whether the instruction now in BRANCH was bne rather than beq.
  logic bne_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= enc(S_FETCH);
`ifdef MC_CONTROLLER_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else if (!in_range) begin
      state_q <= enc(S_FETCH);
    end else begin
      case (state_e'(state_q[STATE_BITS-1:0]))
        S_FETCH:  state_q <= enc(S_DECODE);
        S_DECODE: begin
`ifdef MC_CONTROLLER_BNE_EN
          bne_q <= (op == OP_BNE);
`endif
          case (op)
            OP_LW, OP_SW: state_q <= enc(S_MEMADR);
            OP_RTYPE:     state_q <= enc(S_EXECUTE);
            OP_BEQ:       state_q <= enc(S_BRANCH);
`ifdef MC_CONTROLLER_BNE_EN
            OP_BNE:       state_q <= enc(S_BRANCH);
`endif
            OP_ADDI:      state_q <= enc(S_ADDIEX);
            OP_J:         state_q <= enc(S_JUMP);
            default:      state_q <= enc(S_FETCH);
          endcase
        end
        // An opcode that changed to neither lw nor sw abandons the access safely.
        S_MEMADR: begin
          if (op == OP_LW)      state_q <= enc(S_MEMRD);
          else if (op == OP_SW) state_q <= enc(S_MEMWR);
          else                  state_q <= enc(S_FETCH);
        end
        S_MEMRD:   state_q <= enc(S_MEMWB);
        S_EXECUTE: state_q <= enc(S_ALUWB);
        S_ADDIEX:  state_q <= enc(S_ADDIWB);
        default:   state_q <= enc(S_FETCH);
      endcase
    end
  end

  mc_ctrl_rom #(.STATE_W(STATE_W)) u_rom (
    .state (state_q),
    .ctrl  (ctrl)
  );

`ifdef MC_CONTROLLER_BNE_EN
  assign pcen = ctrl.pcwrite | (ctrl.branch & (zero ^ bne_q));
`else
  assign pcen = ctrl.pcwrite | (ctrl.branch & zero);
`endif

  assign memwrite = ctrl.memwrite;
  assign iord     = ctrl.iord;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign state    = state_q;

endmodule
